writeback_arbiter: RTL

- Initiator side of the register-file write-back interface.
- Buffers results from the adder, multiplier and memory units in per-unit FIFOs.
- Issues one register write at a time, round-robin across the three units, and holds each write until the register file acknowledges it.
- Sits between the functional units and the register file, and replaces direct write_enable driving by each unit.

---
 rtl/writeback_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/writeback_arbiter.sv
// Write-back arbiter: buffers adder/multiplier/memory results in per-unit FIFOs
// and issues one acknowledged register-file write at a time, round-robin.
module writeback_arbiter #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  adder_valid,
  input  logic [ADDR_WIDTH-1:0]                 adder_dest,
  input  logic [DATA_WIDTH-1:0]                 adder_result,
  output logic                                  adder_ready,
  input  logic                                  mult_valid,
  input  logic [ADDR_WIDTH-1:0]                 mult_dest,
  input  logic [DATA_WIDTH-1:0]                 mult_result,
  output logic                                  mult_ready,
  input  logic                                  mem_valid,
  input  logic [ADDR_WIDTH-1:0]                 mem_dest,
  input  logic [DATA_WIDTH-1:0]                 mem_result,
  output logic                                  mem_ready,
  output logic                                  wb_write_enable,
  output logic [ADDR_WIDTH-1:0]                 wb_write_dest,
  output logic [DATA_WIDTH-1:0]                 wb_write_data,
  output logic [1:0]                            wb_unit,
  input  logic                                  wb_ack,
  output logic [$clog2(3*FIFO_DEPTH+1)-1:0]     pending_count,
  output logic                                  timeout_error
);

  localparam int unsigned NUM_UNITS = 3;
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PEND_W    = $clog2(3 * FIFO_DEPTH + 1);
  localparam int unsigned TMO_W     = ($clog2(ACK_TIMEOUT) > 0) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int unsigned ENTRY_W   = ADDR_WIDTH + DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_ACK, S_GAP} state_t;

  state_t                state;
  logic [1:0]            rr_ptr;
  logic [TMO_W-1:0]      tmo_cnt;

  logic [NUM_UNITS-1:0]  in_valid;
  logic [ADDR_WIDTH-1:0] in_dest [NUM_UNITS];
  logic [DATA_WIDTH-1:0] in_data [NUM_UNITS];

  logic [ENTRY_W-1:0]    fifo_mem [NUM_UNITS][FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr   [NUM_UNITS];
  logic [PTR_W-1:0]      rd_ptr   [NUM_UNITS];
  logic [CNT_W-1:0]      cnt      [NUM_UNITS];
  logic [CNT_W-1:0]      cnt_next [NUM_UNITS];
  logic [NUM_UNITS-1:0]  ready_q;

  logic [NUM_UNITS-1:0]  push;
  logic [NUM_UNITS-1:0]  pop;
  logic                  pop_any;
  logic                  tmo_last;
  logic                  grant_valid;
  logic [1:0]            grant_unit;
  logic [2:0]            cand;
  logic [ENTRY_W-1:0]    head_sel;
  logic [PEND_W-1:0]     pending_next;

  assign in_valid   = {mem_valid, mult_valid, adder_valid};
  assign in_dest[0] = adder_dest;
  assign in_dest[1] = mult_dest;
  assign in_dest[2] = mem_dest;
  assign in_data[0] = adder_result;
  assign in_data[1] = mult_result;
  assign in_data[2] = mem_result;

  assign adder_ready = ready_q[0];
  assign mult_ready  = ready_q[1];
  assign mem_ready   = ready_q[2];

  // Handshake, pop, round-robin grant and occupancy bookkeeping
  always_comb begin
    push         = '0;
    pop          = '0;
    grant_valid  = 1'b0;
    grant_unit   = 2'd0;
    cand         = 3'd0;
    head_sel     = '0;
    tmo_last     = (tmo_cnt == TMO_W'(ACK_TIMEOUT - 1));
    pop_any      = (state == S_WAIT_ACK) && (wb_ack || tmo_last);
    for (int u = 0; u < NUM_UNITS; u++) begin
      // dest 0 is handshaken but never buffered
      push[u]     = in_valid[u] && ready_q[u] && (in_dest[u] != '0);
      pop[u]      = pop_any && (wb_unit == 2'(u));
      cnt_next[u] = cnt[u] + CNT_W'(push[u]) - CNT_W'(pop[u]);
    end
    for (int i = 0; i < NUM_UNITS; i++) begin
      cand = 3'(rr_ptr) + 3'(i);
      if (cand >= 3'd3) cand = cand - 3'd3;
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (!grant_valid && (cand == 3'(u)) && (cnt[u] != '0)) begin
          grant_valid = 1'b1;
          grant_unit  = 2'(u);
        end
      end
    end
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (grant_unit == 2'(u)) head_sel = fifo_mem[u][rd_ptr[u]];
    end
    pending_next = pending_count + PEND_W'(push[0]) + PEND_W'(push[1])
                 + PEND_W'(push[2]) - PEND_W'(pop_any);
  end

  // FIFO storage; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (push[u]) fifo_mem[u][wr_ptr[u]] <= {in_dest[u], in_data[u]};
    end
  end

  // FIFO pointers, occupancy, registered ready and total pending count
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        wr_ptr[u] <= '0;
        rd_ptr[u] <= '0;
        cnt[u]    <= '0;
      end
      ready_q       <= '1;
      pending_count <= '0;
    end else begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (push[u]) wr_ptr[u] <= wr_ptr[u] + PTR_W'(1);
        if (pop[u])  rd_ptr[u] <= rd_ptr[u] + PTR_W'(1);
        cnt[u]     <= cnt_next[u];
        ready_q[u] <= (cnt_next[u] != CNT_W'(FIFO_DEPTH));
      end
      pending_count <= pending_next;
    end
  end

  // Issue FSM: grant in IDLE, hold until ack or timeout, then one GAP cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= S_IDLE;
      rr_ptr          <= 2'd0;
      tmo_cnt         <= '0;
      wb_write_enable <= 1'b0;
      wb_write_dest   <= '0;
      wb_write_data   <= '0;
      wb_unit         <= 2'd0;
      timeout_error   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_valid) begin
            wb_write_enable <= 1'b1;
            {wb_write_dest, wb_write_data} <= head_sel;
            wb_unit         <= grant_unit;
            rr_ptr          <= (grant_unit == 2'd2) ? 2'd0 : grant_unit + 2'd1;
            tmo_cnt         <= '0;
            state           <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (wb_ack) begin
            wb_write_enable <= 1'b0;
            state           <= S_GAP;
          end else if (tmo_last) begin
            timeout_error   <= 1'b1;
            wb_write_enable <= 1'b0;
            state           <= S_GAP;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        S_GAP: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
